// File: rtl/temporal_encoder_ngram_pkg.sv
// Shared definitions for the N-gram temporal encoder.
// Holds the default sizes used when the encoder is instantiated without
// overrides, plus the helper that maps a requested N-gram size onto the
// supported range.
package temporal_encoder_ngram_pkg;

    localparam int HV_DIMENSION_DEF = 1024;
    localparam int MODE_WIDTH_DEF   = 2;
    localparam int LABEL_WIDTH_DEF  = 5;
    localparam int NGRAM_MAX_DEF    = 5;

    // A requested size of 0 means "no binding", which is the same as N=1.
    // Sizes above the history depth saturate at the deepest supported window.
    function automatic int clamp_ngram(input int size, input int max_n);
        if (size < 1) begin
            return 1;
        end
        if (size > max_n) begin
            return max_n;
        end
        return size;
    endfunction

endpackage

// File: rtl/temporal_encoder_ngram_history.sv
// History store for the N-gram temporal encoder.
// Keeps the last NGRAM_MAX-1 accepted hypervectors (hist_o[0] is the most
// recent), the window fill count and the tags/size the current window was
// built with. A tag or size change on a non-empty window restarts it.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   accept_i      : an input is consumed this cycle
//   hv_i          : hypervector being consumed
//   mode_i/label_i: tags of the consumed hypervector
//   n_i           : effective (already clamped) N for the consumed input
//   hist_o        : pre-shift history, valid during the accepting cycle
//   emit_o        : the consumed input completes an N-gram window
module temporal_encoder_ngram_history
    import temporal_encoder_ngram_pkg::*;
#(
    parameter int HV_DIMENSION = HV_DIMENSION_DEF,
    parameter int MODE_WIDTH   = MODE_WIDTH_DEF,
    parameter int LABEL_WIDTH  = LABEL_WIDTH_DEF,
    parameter int NGRAM_MAX    = NGRAM_MAX_DEF,
    parameter int NGRAM_WIDTH  = $clog2(NGRAM_MAX + 1),
    parameter int HIST_DEPTH   = (NGRAM_MAX > 1) ? NGRAM_MAX - 1 : 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     accept_i,
    input  logic [0:HV_DIMENSION-1]                  hv_i,
    input  logic [MODE_WIDTH-1:0]                    mode_i,
    input  logic [LABEL_WIDTH-1:0]                   label_i,
    input  logic [NGRAM_WIDTH-1:0]                   n_i,
    output logic [HIST_DEPTH-1:0][0:HV_DIMENSION-1]  hist_o,
    output logic                                     emit_o
);

    logic [HIST_DEPTH-1:0][0:HV_DIMENSION-1] hist_q, hist_d;
    logic [NGRAM_WIDTH-1:0]                  fill_q, fill_d;
    logic [NGRAM_WIDTH-1:0]                  n_q, n_d;
    logic [MODE_WIDTH-1:0]                   mode_q, mode_d;
    logic [LABEL_WIDTH-1:0]                  label_q, label_d;
    logic                                    restart;

    assign restart = (fill_q != '0) &&
                     ((mode_i != mode_q) || (label_i != label_q) || (n_i != n_q));

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        n_d     = n_q;
        mode_d  = mode_q;
        label_d = label_q;
        if (accept_i) begin
            if (restart) begin
                hist_d    = '0;
                hist_d[0] = hv_i;
                fill_d    = NGRAM_WIDTH'(1);
            end else begin
                for (int k = HIST_DEPTH - 1; k >= 1; k--) begin
                    hist_d[k] = hist_q[k-1];
                end
                hist_d[0] = hv_i;
                // Saturate at n; the compare avoids wrapping when n is the
                // largest value the counter width can hold.
                fill_d = (fill_q >= n_i) ? n_i : fill_q + NGRAM_WIDTH'(1);
            end
            n_d     = n_i;
            mode_d  = mode_i;
            label_d = label_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q  <= '0;
            fill_q  <= '0;
            n_q     <= '0;
            mode_q  <= '0;
            label_q <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            label_q <= label_d;
        end
    end

    assign emit_o = accept_i && (fill_d == n_i);
    assign hist_o = hist_q;

endmodule

// File: rtl/temporal_encoder_ngram.sv
// N-gram temporal encoder: binds the current hypervector with rotated copies
// of the previous n-1 accepted hypervectors,
//   ngram = x[t] ^ rho(x[t-1]) ^ ... ^ rho^(n-1)(x[t-n+1]),
// where rho rotates toward higher indices: rho(x) = {x[D-1], x[0:D-2]}.
//   Clk_CI, Rst_RBI       : clock, asynchronous active-low reset
//   ValidIn_SI/ReadyOut_SO: input handshake
//   ModeIn_SI, LabelIn_SI : tags of the input hypervector
//   NgramSize_SI          : requested N (0 acts as 1, saturates at NGRAM_MAX)
//   HypervectorIn_DI      : input hypervector
//   ValidOut_SO/ReadyIn_SI: output handshake
//   ModeOut_SO, LabelOut_DO, HypervectorOut_DO: registered N-gram and tags
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The output side holds data and tags stable while ValidOut_SO
// is high and ReadyIn_SI is low. ReadyOut_SO = ~ValidOut_SO | ReadyIn_SI, so
// a new N-gram can replace the one being handed off in the same cycle.
module temporal_encoder_ngram
    import temporal_encoder_ngram_pkg::*;
#(
    parameter int HV_DIMENSION = HV_DIMENSION_DEF,
    parameter int MODE_WIDTH   = MODE_WIDTH_DEF,
    parameter int LABEL_WIDTH  = LABEL_WIDTH_DEF,
    parameter int NGRAM_MAX    = NGRAM_MAX_DEF,
    parameter int NGRAM_WIDTH  = $clog2(NGRAM_MAX + 1)
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RBI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [MODE_WIDTH-1:0]   ModeIn_SI,
    input  logic [LABEL_WIDTH-1:0]  LabelIn_DI,
    input  logic [NGRAM_WIDTH-1:0]  NgramSize_SI,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [MODE_WIDTH-1:0]   ModeOut_SO,
    output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

    localparam int HIST_DEPTH = (NGRAM_MAX > 1) ? NGRAM_MAX - 1 : 1;

    logic                                    accept;
    logic                                    emit;
    logic [NGRAM_WIDTH-1:0]                  n_eff;
    logic [HIST_DEPTH-1:0][0:HV_DIMENSION-1] hist;
    logic [0:HV_DIMENSION-1]                 ngram;

    logic                    valid_q, valid_d;
    logic [MODE_WIDTH-1:0]   mode_q, mode_d;
    logic [LABEL_WIDTH-1:0]  label_q, label_d;
    logic [0:HV_DIMENSION-1] hv_q, hv_d;

    assign ReadyOut_SO = ~valid_q | ReadyIn_SI;
    assign accept      = ValidIn_SI & ReadyOut_SO;
    assign n_eff       = NGRAM_WIDTH'(clamp_ngram(int'(NgramSize_SI), NGRAM_MAX));

    temporal_encoder_ngram_history #(
        .HV_DIMENSION (HV_DIMENSION),
        .MODE_WIDTH   (MODE_WIDTH),
        .LABEL_WIDTH  (LABEL_WIDTH),
        .NGRAM_MAX    (NGRAM_MAX),
        .NGRAM_WIDTH  (NGRAM_WIDTH),
        .HIST_DEPTH   (HIST_DEPTH)
    ) u_history (
        .clk_i    (Clk_CI),
        .rst_ni   (Rst_RBI),
        .accept_i (accept),
        .hv_i     (HypervectorIn_DI),
        .mode_i   (ModeIn_SI),
        .label_i  (LabelIn_DI),
        .n_i      (n_eff),
        .hist_o   (hist),
        .emit_o   (emit)
    );

    // hist[k-1] holds x[t-k]; it is rotated by k positions before binding.
    // Entries at or beyond n are ignored. On a restart only n = 1 can emit,
    // in which case no history term is included anyway.
    always_comb begin
        ngram = HypervectorIn_DI;
        for (int k = 1; k < NGRAM_MAX; k++) begin
            if (k < int'(n_eff)) begin
                for (int i = 0; i < HV_DIMENSION; i++) begin
                    ngram[i] = ngram[i] ^
                        hist[k-1][((i - (k % HV_DIMENSION)) + HV_DIMENSION) % HV_DIMENSION];
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        label_d = label_q;
        hv_d    = hv_q;
        if (emit) begin
            valid_d = 1'b1;
            mode_d  = ModeIn_SI;
            label_d = LabelIn_DI;
            hv_d    = ngram;
        end else if (ReadyIn_SI) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            valid_q <= 1'b0;
            mode_q  <= '0;
            label_q <= '0;
            hv_q    <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            label_q <= label_d;
            hv_q    <= hv_d;
        end
    end

    assign ValidOut_SO       = valid_q;
    assign ModeOut_SO        = mode_q;
    assign LabelOut_DO       = label_q;
    assign HypervectorOut_DO = hv_q;

endmodule

// File: tb/tb_temporal_encoder_ngram.sv
// Testbench for temporal_encoder_ngram with D=8, 2-bit tags, NGRAM_MAX=5.
// Vectors are held in [7:0] variables whose bit 7 is hypervector bit 0, so
// one rotation step is a right rotate: {x[0], x[7:1]}.
module tb_temporal_encoder_ngram;

    localparam int D   = 8;
    localparam int MW  = 2;
    localparam int LW  = 2;
    localparam int NMX = 5;
    localparam int NW  = $clog2(NMX + 1);
    localparam int W   = MW + LW + D;

    logic          clk;
    logic          rst_n;
    logic          valid_in;
    logic          ready_out;
    logic [MW-1:0] mode_in;
    logic [LW-1:0] label_in;
    logic [NW-1:0] size_in;
    logic [D-1:0]  hv_in;
    logic          valid_out;
    logic          ready_in;
    logic [MW-1:0] mode_out;
    logic [LW-1:0] label_out;
    logic [D-1:0]  hv_out;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // Reference model state: accepted vectors of the current window, newest first.
    logic [D-1:0]  win[$];
    logic [MW-1:0] m_mode;
    logic [LW-1:0] m_label;
    int            m_n;

    temporal_encoder_ngram #(
        .HV_DIMENSION (D),
        .MODE_WIDTH   (MW),
        .LABEL_WIDTH  (LW),
        .NGRAM_MAX    (NMX)
    ) dut (
        .Clk_CI            (clk),
        .Rst_RBI           (rst_n),
        .ValidIn_SI        (valid_in),
        .ReadyOut_SO       (ready_out),
        .ModeIn_SI         (mode_in),
        .LabelIn_DI        (label_in),
        .NgramSize_SI      (size_in),
        .HypervectorIn_DI  (hv_in),
        .ValidOut_SO       (valid_out),
        .ReadyIn_SI        (ready_in),
        .ModeOut_SO        (mode_out),
        .LabelOut_DO       (label_out),
        .HypervectorOut_DO (hv_out)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [D-1:0] rot(input logic [D-1:0] x, input int k);
        logic [D-1:0] r;
        r = x;
        for (int j = 0; j < k; j++) begin
            r = {r[0], r[D-1:1]};
        end
        return r;
    endfunction

    task automatic model_reset();
        win.delete();
        exp_q.delete();
        m_mode  = '0;
        m_label = '0;
        m_n     = 0;
    endtask

    task automatic model_accept(input logic [D-1:0] hv, input logic [MW-1:0] md,
                                input logic [LW-1:0] lb, input logic [NW-1:0] sz);
        int n;
        logic [D-1:0] res;
        n = (sz == 0) ? 1 : ((int'(sz) > NMX) ? NMX : int'(sz));
        if (win.size() != 0 && (md != m_mode || lb != m_label || n != m_n)) begin
            win.delete();
        end
        win.push_front(hv);
        while (win.size() > n) begin
            void'(win.pop_back());
        end
        m_mode  = md;
        m_label = lb;
        m_n     = n;
        if (win.size() == n) begin
            res = '0;
            for (int k = 0; k < n; k++) begin
                res = res ^ rot(win[k], k);
            end
            exp_q.push_back({md, lb, res});
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && valid_out && ready_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_output got=%h (nothing expected)",
                         {mode_out, label_out, hv_out});
            end else begin
                e = exp_q.pop_front();
                if ({mode_out, label_out, hv_out} !== e) begin
                    errors++;
                    $display("FAIL sb_output got=%h exp=%h", {mode_out, label_out, hv_out}, e);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [D-1:0] hv, input logic [MW-1:0] md,
                        input logic [LW-1:0] lb, input logic [NW-1:0] sz);
        int  waited;
        logic ok;
        waited   = 0;
        ok       = 1'b0;
        valid_in = 1'b1;
        hv_in    = hv;
        mode_in  = md;
        label_in = lb;
        size_in  = sz;
        while (!ok && waited <= 50) begin
            @(negedge clk);
            if (ready_out) begin
                ok = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ready_out=%b exp=1", ready_out);
        end else begin
            model_accept(hv, md, lb, sz);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        mode_in  = '0;
        label_in = '0;
        size_in  = '0;
        hv_in    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        checks++;
        if (hv_out !== 8'h00) begin errors++; $display("FAIL reset_hv got=%h exp=00", hv_out); end
        checks++;
        if ({mode_out, label_out} !== 4'h0) begin
            errors++; $display("FAIL reset_tags got=%h exp=0", {mode_out, label_out});
        end
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_n3();
        send(8'h80, 2'd0, 2'd0, 3'd3);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL n3_first_valid got=%b exp=0", valid_out); end
        send(8'h80, 2'd0, 2'd0, 3'd3);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL n3_second_valid got=%b exp=0", valid_out); end
        send(8'h80, 2'd0, 2'd0, 3'd3);
        checks++;
        if (valid_out !== 1'b1 || hv_out !== 8'hE0) begin
            errors++; $display("FAIL n3_third got=%b/%h exp=1/e0", valid_out, hv_out);
        end
        send(8'h80, 2'd0, 2'd0, 3'd3);
        checks++;
        if (valid_out !== 1'b1 || hv_out !== 8'hE0) begin
            errors++; $display("FAIL n3_slide got=%b/%h exp=1/e0", valid_out, hv_out);
        end
    endtask

    task automatic test_n1();
        send(8'h55, 2'd0, 2'd0, 3'd1);
        checks++;
        if (valid_out !== 1'b1 || hv_out !== 8'h55) begin
            errors++; $display("FAIL n1_first got=%b/%h exp=1/55", valid_out, hv_out);
        end
        send(8'h0F, 2'd0, 2'd0, 3'd1);
        checks++;
        if (valid_out !== 1'b1 || hv_out !== 8'h0F) begin
            errors++; $display("FAIL n1_second got=%b/%h exp=1/0f", valid_out, hv_out);
        end
    endtask

    task automatic test_label_restart();
        send(8'hFF, 2'd0, 2'd0, 3'd3);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL lbl_size_restart_valid got=%b exp=0", valid_out); end
        send(8'hF0, 2'd0, 2'd0, 3'd3);
        send(8'h01, 2'd0, 2'd1, 3'd3);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL lbl_restart_valid got=%b exp=0", valid_out); end
        send(8'h02, 2'd0, 2'd1, 3'd3);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL lbl_refill_valid got=%b exp=0", valid_out); end
        send(8'h04, 2'd0, 2'd1, 3'd3);
        checks++;
        if (valid_out !== 1'b1 || hv_out !== 8'h45 || label_out !== 2'd1) begin
            errors++;
            $display("FAIL lbl_emit got=%b/%h/%0d exp=1/45/1", valid_out, hv_out, label_out);
        end
    endtask

    task automatic test_backpressure();
        ready_in = 1'b0;
        valid_in = 1'b1;
        hv_in    = 8'h08;
        mode_in  = 2'd0;
        label_in = 2'd1;
        size_in  = 3'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (ready_out !== 1'b0 || valid_out !== 1'b1 || hv_out !== 8'h45 || label_out !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold c=%0d got=%b/%b/%h/%0d exp=0/1/45/1",
                         c, ready_out, valid_out, hv_out, label_out);
            end
            @(posedge clk);
            #1;
        end
        ready_in = 1'b1;
        send(8'h08, 2'd0, 2'd1, 3'd3);
        checks++;
        if (valid_out !== 1'b1 || hv_out !== 8'h8A) begin
            errors++; $display("FAIL bp_resume got=%b/%h exp=1/8a", valid_out, hv_out);
        end
    endtask

    task automatic test_size_clamp();
        send(8'hA5, 2'd0, 2'd0, 3'd0);
        checks++;
        if (valid_out !== 1'b1 || hv_out !== 8'hA5) begin
            errors++; $display("FAIL size0_as_n1 got=%b/%h exp=1/a5", valid_out, hv_out);
        end
        send(8'h80, 2'd0, 2'd0, 3'd7);
        for (int i = 0; i < 3; i++) begin
            send(8'h00, 2'd0, 2'd0, 3'd7);
            checks++;
            if (valid_out !== 1'b0) begin
                errors++; $display("FAIL size7_fill i=%0d got=%b exp=0", i, valid_out);
            end
        end
        send(8'h00, 2'd0, 2'd0, 3'd7);
        checks++;
        if (valid_out !== 1'b1 || hv_out !== 8'h08) begin
            errors++; $display("FAIL size7_as_n5 got=%b/%h exp=1/08", valid_out, hv_out);
        end
        send(8'h11, 2'd0, 2'd0, 3'd3);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL size_change_restart got=%b exp=0", valid_out); end
        send(8'h22, 2'd0, 2'd0, 3'd3);
        send(8'h44, 2'd0, 2'd0, 3'd3);
        checks++;
        if (valid_out !== 1'b1 || hv_out !== 8'h11) begin
            errors++; $display("FAIL size_change_emit got=%b/%h exp=1/11", valid_out, hv_out);
        end
    endtask

    task automatic test_reset_mid();
        send(8'h01, 2'd1, 2'd2, 3'd3);
        send(8'h02, 2'd1, 2'd2, 3'd3);
        send(8'h04, 2'd1, 2'd2, 3'd3);
        ready_in = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (valid_out !== 1'b0 || hv_out !== 8'h00 || {mode_out, label_out} !== 4'h0) begin
            errors++;
            $display("FAIL async_reset got=%b/%h/%h exp=0/00/0", valid_out, hv_out, {mode_out, label_out});
        end
        @(negedge clk);
        #2;
        rst_n    = 1'b1;
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        send(8'h01, 2'd1, 2'd2, 3'd3);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL post_reset_1 got=%b exp=0", valid_out); end
        send(8'h02, 2'd1, 2'd2, 3'd3);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL post_reset_2 got=%b exp=0", valid_out); end
        send(8'h04, 2'd1, 2'd2, 3'd3);
        checks++;
        if (valid_out !== 1'b1 || hv_out !== 8'h45 || mode_out !== 2'd1) begin
            errors++; $display("FAIL post_reset_3 got=%b/%h/%0d exp=1/45/1", valid_out, hv_out, mode_out);
        end
    endtask

    task automatic test_random_stream();
        logic          took;
        logic [MW-1:0] md;
        logic [LW-1:0] lb;
        logic [NW-1:0] sz;
        took = 1'b1;
        md   = 2'd0;
        lb   = 2'd0;
        sz   = 3'd3;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!valid_in || took) begin
                if ($urandom_range(0, 9) == 0) md = MW'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) lb = LW'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) sz = NW'($urandom_range(0, 7));
                valid_in = ($urandom_range(0, 3) != 0);
                hv_in    = D'($urandom_range(0, 255));
                mode_in  = md;
                label_in = lb;
                size_in  = sz;
            end
            ready_in = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = valid_in && ready_out;
            if (took) begin
                model_accept(hv_in, mode_in, label_in, size_in);
            end
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rand_drain pending=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_n3();
        test_n1();
        test_label_restart();
        test_backpressure();
        test_size_clamp();
        test_reset_mid();
        test_random_stream();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/temporal_encoder_ngram.md
# temporal_encoder_ngram

Parametrised N-gram temporal encoder for the HD pipeline. Sits between the spatial encoder and the associative memory / training stage. Binds the current hypervector with rotated copies of the previous N-1 accepted hypervectors: ngram = x[t] ⊕ ρ(x[t-1]) ⊕ … ⊕ ρ^(n-1)(x[t-n+1]). Adds three things over the fixed-N encoder: run-time N-gram size, automatic window restart on mode/label/size change, and a full valid/ready output register with backpressure.

## Interface
- HV_DIMENSION, `HV_DIMENSION, hypervector width in bits (bit 0 is MSB-side, vectors declared [0:HV_DIMENSION-1])
- MODE_WIDTH, `MODE_WIDTH, mode field width
- LABEL_WIDTH, `LABEL_WIDTH, label field width
- NGRAM_MAX, 5, maximum supported N (≥1)
- NGRAM_WIDTH, $clog2(NGRAM_MAX+1), width of size input (derived, do not override)

- Clk_CI  in  1  clock, all state on rising edge
- Rst_RBI  in  1  reset, asynchronous, active-low
- ValidIn_SI  in  1  input valid
- ReadyOut_SO  out  1  block can accept input
- ModeIn_SI  in  MODE_WIDTH  mode tag of input
- LabelIn_DI  in  LABEL_WIDTH  label tag of input
- NgramSize_SI  in  NGRAM_WIDTH  requested N for this input
- HypervectorIn_DI  in  HV_DIMENSION  input hypervector
- ValidOut_SO  out  1  output valid
- ReadyIn_SI  in  1  downstream ready
- ModeOut_SO  out  MODE_WIDTH  mode of emitted N-gram
- LabelOut_DO  out  LABEL_WIDTH  label of emitted N-gram
- HypervectorOut_DO  out  HV_DIMENSION  N-gram hypervector

## Operation
- Rotation: ρ(x)[i] = x[(i-1) mod D], i.e. ρ(x) = {x[D-1], x[0:D-2]}; ρ^k applied k times.
- Effective size n = NgramSize_SI clamped to [1, NGRAM_MAX]; 0 → 1.
- State: history h[1..NGRAM_MAX-1] (h[1] = most recent accepted), fill counter 0..NGRAM_MAX, latched mode/label/n, output register.
- Accept = ValidIn_SI & ReadyOut_SO.
- Restart condition on accept: fill ≠ 0 and (ModeIn ≠ latched mode or LabelIn ≠ latched label or n ≠ latched n). On restart, history treated as empty: fill ← 1, h[1] ← input, h[2..] ← 0, tags/n relatched. No output produced for the restarting input unless n = 1.
- Normal accept: h[k] ← h[k-1], h[1] ← input, fill ← min(fill+1, n), tags/n latched.
- Emit when post-accept fill = n: output register ← input ⊕ ⊕_{k=1..n-1} ρ^k(h[k]) (pre-shift history), with input mode/label; ValidOut_SO ← 1. Windows slide by one: every accepted input after fill reaches n emits.
- n = 1: every accept emits the input unchanged.

## Timing
- Reset values: ValidOut_SO 0, ModeOut_SO/LabelOut_DO/HypervectorOut_DO all 0, fill 0, history 0, ReadyOut_SO 1.
- Latency: accept at edge t → ValidOut_SO high from t (registered), visible cycle after input presented.
- ReadyOut_SO = ~ValidOut_SO | ReadyIn_SI (combinational); full throughput 1 N-gram/cycle with ReadyIn_SI held high.
- Output held stable while ValidOut_SO & ~ReadyIn_SI; ValidOut_SO clears on handshake with no simultaneous emit.
- Handshake out and accept in same cycle: new N-gram replaces old, ValidOut_SO stays 1.
- Accept that does not emit (fill < n) while output handshaking: ValidOut_SO → 0.
- Inputs ignored when not accepted; history untouched.
- Rst_RBI asserted mid-window or with pending output: all state cleared immediately, pending N-gram dropped.

## Structure
- const.vh: NGRAM_MAX default, existing `HV_DIMENSION/`MODE_WIDTH/`LABEL_WIDTH.
- Sub-module ngram_history: history shift register, fill counter, restart compare, latched tags; parent holds rotate/XOR tree and output register.

## Test plan
- D=8, n=3, same mode/label, inputs 10000000 ×3 → no output after 1st, 2nd; after 3rd HypervectorOut_DO = 11100000; 4th input 10000000 → 11100000 again.
- n=1, inputs 01010101, 00001111 → outputs identical to inputs, one per cycle, no gaps.
- n=3, two inputs label 0, then label 1 input → no output; two more label 1 inputs → first emit carries LabelOut_DO = 1 and uses only label 1 vectors.
- ReadyIn_SI low 4 cycles with ValidOut_SO high → output bits/tags stable, ReadyOut_SO 0, no input consumed; release → handshake, stream resumes without loss.
- Rst_RBI pulsed low after 2 of 3 inputs, asynchronously off-edge → outputs 0 at once; next 3 inputs required before first emit.
- NgramSize_SI = 0 and = 7 (NGRAM_MAX 5) → behave as n=1 and n=5; size change mid-stream → restart, no emit until refilled.
